dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_pkg.sv | 13 +
 rtl/dm_arbiter_if.sv | 38 +++
 rtl/dm_arbiter_rr_picker.sv | 37 +++
 rtl/dm_arbiter.sv | 108 ++++++++++
 tb/tb_dm_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: status encodings and default widths.
package dm_arbiter_pkg;

    localparam int unsigned NUM_CORES_DEF = 4;
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned ADDR_W_DEF    = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DUMP = 2'd3;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of system-mode, com-port, per-core and data-memory signals around dm_arbiter.
interface dm_arbiter_if
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES = NUM_CORES_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) ();

    logic [1:0]                  status;
    logic [DATA_W-1:0]           com_data_in;
    logic [ADDR_W-1:0]           com_addr;
    logic                        com_wr_en;
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_wr_en;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_data;
    logic [NUM_CORES-1:0]        core_lock;
    logic [NUM_CORES-1:0]        core_grant;
    logic [NUM_CORES-1:0]        core_rvalid;
    logic [DATA_W-1:0]           DM_data_in;
    logic [ADDR_W-1:0]           DM_addr;
    logic                        DM_write_en;
    logic                        arb_busy;

    modport slave (
        input  status, com_data_in, com_addr, com_wr_en,
        input  core_req, core_wr_en, core_addr, core_data, core_lock,
        output core_grant, core_rvalid, DM_data_in, DM_addr, DM_write_en, arb_busy
    );

    modport master (
        output status, com_data_in, com_addr, com_wr_en,
        output core_req, core_wr_en, core_addr, core_data, core_lock,
        input  core_grant, core_rvalid, DM_data_in, DM_addr, DM_write_en, arb_busy
    );

endinterface

// File: rtl/dm_arbiter_rr_picker.sv
// Round-robin picker: first requester found searching upward from ptr_i+1, wrapping.
module rr_picker
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES = NUM_CORES_DEF,
    parameter int unsigned PTR_W     = 2
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic [NUM_CORES-1:0] gnt_o,
    output logic                 valid_o,
    output logic [PTR_W-1:0]     idx_o
);

    localparam int unsigned SUM_W = PTR_W + 1;

    logic [SUM_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned off = 1; off <= NUM_CORES; off++) begin
            cand = SUM_W'(ptr_i) + SUM_W'(off);
            if (cand >= SUM_W'(NUM_CORES)) begin
                cand = cand - SUM_W'(NUM_CORES);
            end
            if (!valid_o && req_i[cand[PTR_W-1:0]]) begin
                valid_o                  = 1'b1;
                gnt_o[cand[PTR_W-1:0]]   = 1'b1;
                idx_o                    = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: com port owns memory in LOAD/DUMP, cores round-robin in RUN.
// Define DM_ARBITER_LOCK_EN to let a granted core hold the memory with core_lock.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CORES = NUM_CORES_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    dm_arbiter_if.slave   dm_io
);

    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
    logic                 we_q, we_d;
    logic                 busy_q, busy_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;

    logic [NUM_CORES-1:0] elig_c, pick_gnt_c;
    logic                 pick_valid_c, hold_c;
    logic [PTR_W-1:0]     pick_idx_c, sel_c;

    // The core granted this cycle sits out the next decision.
    assign elig_c = dm_io.core_req & ~grant_q;

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .PTR_W     (PTR_W)
    ) u_rr_picker (
        .req_i   (elig_c),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt_c),
        .valid_o (pick_valid_c),
        .idx_o   (pick_idx_c)
    );

`ifdef DM_ARBITER_LOCK_EN
    assign hold_c = |(grant_q & dm_io.core_lock & dm_io.core_req);
`else
    logic unused_lock_c;
    assign unused_lock_c = ^dm_io.core_lock;
    assign hold_c        = 1'b0;
`endif

    // A held grant belongs to the last winner, which ptr_q already names.
    always_comb begin
        grant_d  = '0;
        rvalid_d = we_q ? '0 : grant_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        ptr_d    = ptr_q;
        busy_d   = 1'b0;
        sel_c    = hold_c ? ptr_q : pick_idx_c;
        case (dm_io.status)
            ST_LOAD, ST_DUMP: begin
                addr_d = dm_io.com_addr;
                data_d = dm_io.com_data_in;
                we_d   = (dm_io.status == ST_LOAD) && dm_io.com_wr_en;
            end
            ST_RUN: begin
                busy_d = |dm_io.core_req;
                if (hold_c || pick_valid_c) begin
                    grant_d = hold_c ? grant_q : pick_gnt_c;
                    ptr_d   = sel_c;
                    addr_d  = dm_io.core_addr[32'(sel_c)*ADDR_W +: ADDR_W];
                    data_d  = dm_io.core_data[32'(sel_c)*DATA_W +: DATA_W];
                    we_d    = dm_io.core_wr_en[sel_c];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q  <= '0;
            rvalid_q <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            ptr_q    <= PTR_W'(NUM_CORES - 1);
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            grant_q  <= grant_d;
            rvalid_q <= rvalid_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign dm_io.core_grant  = grant_q;
    assign dm_io.core_rvalid = rvalid_q;
    assign dm_io.DM_write_en = we_q;
    assign dm_io.DM_addr     = addr_q;
    assign dm_io.DM_data_in  = data_q;
    assign dm_io.arb_busy    = busy_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: per-step expectations queued with stimulus, compared after each edge.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;

    typedef struct packed {
        logic [1:0]  status;
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [3:0]  lock;
        logic        cwe;
        logic [15:0] caddr;
        logic [15:0] cdata;
    } stim_t;

    typedef struct packed {
        logic [3:0]  grant;
        logic [3:0]  rvalid;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    dm_arbiter_if #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW)) dm_if ();

    dm_arbiter #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .dm_io (dm_if)
    );

    function automatic stim_t mk_s(input logic [1:0] st, input logic [3:0] req, input logic [3:0] wr,
                                   input logic [3:0] lock, input logic cwe, input logic [15:0] ca,
                                   input logic [15:0] cd);
        stim_t s;
        s.status = st; s.req = req; s.wr = wr; s.lock = lock;
        s.cwe = cwe; s.caddr = ca; s.cdata = cd;
        return s;
    endfunction

    function automatic exp_t mk_e(input logic [3:0] g, input logic [3:0] rv, input logic we,
                                  input logic [15:0] a, input logic [15:0] d, input logic b);
        exp_t e;
        e.grant = g; e.rvalid = rv; e.we = we; e.addr = a; e.data = d; e.busy = b;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.grant  = dm_if.core_grant;
        o.rvalid = dm_if.core_rvalid;
        o.we     = dm_if.DM_write_en;
        o.addr   = dm_if.DM_addr;
        o.data   = dm_if.DM_data_in;
        o.busy   = dm_if.arb_busy;
        return o;
    endfunction

    task automatic apply(input stim_t s);
        dm_if.status      = s.status;
        dm_if.core_req    = s.req;
        dm_if.core_wr_en  = s.wr;
        dm_if.core_lock   = s.lock;
        dm_if.com_wr_en   = s.cwe;
        dm_if.com_addr    = s.caddr;
        dm_if.com_data_in = s.cdata;
    endtask

    task automatic push(input stim_t s, input exp_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        apply(mk_s(ST_IDLE, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 16'h0));
        #1 rst = 1'b1;
        exp_q.push_back(mk_e(4'h0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0));
        exp_q.push_back(mk_e(4'h0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0));
        #2;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) $display("FAIL reset step %0d: got %p expected %p", k, o, e);
            else passed++;
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_com_port();
        exp_t e, o;
        int   k = 0;
        push(mk_s(ST_LOAD, 4'h0, 4'h0, 4'h0, 1'b1, 16'h0010, 16'hBEEF), mk_e(4'h0, 4'h0, 1'b1, 16'h0010, 16'hBEEF, 1'b0));
        push(mk_s(ST_LOAD, 4'hF, 4'hF, 4'h0, 1'b1, 16'h0011, 16'h1234), mk_e(4'h0, 4'h0, 1'b1, 16'h0011, 16'h1234, 1'b0));
        push(mk_s(ST_DUMP, 4'h0, 4'h0, 4'h0, 1'b1, 16'h0020, 16'h5555), mk_e(4'h0, 4'h0, 1'b0, 16'h0020, 16'h5555, 1'b0));
        push(mk_s(ST_IDLE, 4'h0, 4'h0, 4'h0, 1'b1, 16'h0030, 16'h6666), mk_e(4'h0, 4'h0, 1'b0, 16'h0020, 16'h5555, 1'b0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) $display("FAIL com_port step %0d: got %p expected %p", k, o, e);
            else passed++;
            k++;
        end
    endtask

    task automatic test_rr_reads();
        exp_t e, o;
        int   k = 0;
        stim_t all = mk_s(ST_RUN, 4'hF, 4'h0, 4'h0, 1'b0, 16'h0, 16'h0);
        stim_t none = mk_s(ST_RUN, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 16'h0);
        push(all,  mk_e(4'b0001, 4'b0000, 1'b0, 16'h0100, 16'hD000, 1'b1));
        push(all,  mk_e(4'b0010, 4'b0001, 1'b0, 16'h0101, 16'hD001, 1'b1));
        push(all,  mk_e(4'b0100, 4'b0010, 1'b0, 16'h0102, 16'hD002, 1'b1));
        push(all,  mk_e(4'b1000, 4'b0100, 1'b0, 16'h0103, 16'hD003, 1'b1));
        push(all,  mk_e(4'b0001, 4'b1000, 1'b0, 16'h0100, 16'hD000, 1'b1));
        push(none, mk_e(4'b0000, 4'b0001, 1'b0, 16'h0100, 16'hD000, 1'b0));
        push(none, mk_e(4'b0000, 4'b0000, 1'b0, 16'h0100, 16'hD000, 1'b0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) $display("FAIL rr_reads step %0d: got %p expected %p", k, o, e);
            else passed++;
            k++;
        end
    endtask

    task automatic test_lone_writer();
        exp_t e, o;
        int   k = 0;
        stim_t w = mk_s(ST_RUN, 4'b0100, 4'b0100, 4'h0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            push(w, mk_e(4'b0100, 4'b0000, 1'b1, 16'h0102, 16'hD002, 1'b1));
            push(w, mk_e(4'b0000, 4'b0000, 1'b0, 16'h0102, 16'hD002, 1'b1));
        end
        push(mk_s(ST_RUN, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 16'h0), mk_e(4'b0000, 4'b0000, 1'b0, 16'h0102, 16'hD002, 1'b0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) $display("FAIL lone_writer step %0d: got %p expected %p", k, o, e);
            else passed++;
            k++;
        end
    endtask

    task automatic test_lock();
        exp_t e, o;
        int   k = 0;
        stim_t both = mk_s(ST_RUN, 4'b1010, 4'h0, 4'b0010, 1'b0, 16'h0, 16'h0);
        stim_t c3   = mk_s(ST_RUN, 4'b1000, 4'h0, 4'h0, 1'b0, 16'h0, 16'h0);
        apply(mk_s(ST_IDLE, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 16'h0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef DM_ARBITER_LOCK_EN
        push(both, mk_e(4'b0010, 4'b0000, 1'b0, 16'h0101, 16'hD001, 1'b1));
        push(both, mk_e(4'b0010, 4'b0010, 1'b0, 16'h0101, 16'hD001, 1'b1));
        push(both, mk_e(4'b0010, 4'b0010, 1'b0, 16'h0101, 16'hD001, 1'b1));
`else
        push(both, mk_e(4'b0010, 4'b0000, 1'b0, 16'h0101, 16'hD001, 1'b1));
        push(both, mk_e(4'b1000, 4'b0010, 1'b0, 16'h0103, 16'hD003, 1'b1));
        push(both, mk_e(4'b0010, 4'b1000, 1'b0, 16'h0101, 16'hD001, 1'b1));
`endif
        push(c3, mk_e(4'b1000, 4'b0010, 1'b0, 16'h0103, 16'hD003, 1'b1));
        push(c3, mk_e(4'b0000, 4'b1000, 1'b0, 16'h0103, 16'hD003, 1'b1));
        push(mk_s(ST_RUN, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0, 16'h0), mk_e(4'b0000, 4'b0000, 1'b0, 16'h0103, 16'hD003, 1'b0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) $display("FAIL lock step %0d: got %p expected %p", k, o, e);
            else passed++;
            k++;
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e, o;
        exp_t zero = mk_e(4'h0, 4'h0, 1'b0, 16'h0, 16'h0, 1'b0);
        apply(mk_s(ST_RUN, 4'b0011, 4'b0011, 4'h0, 1'b0, 16'h0, 16'h0));
        exp_q.push_back(mk_e(4'b0001, 4'b0000, 1'b1, 16'h0100, 16'hD000, 1'b1));
        exp_q.push_back(zero);
        exp_q.push_back(zero);
        exp_q.push_back(mk_e(4'b0001, 4'b0000, 1'b1, 16'h0100, 16'hD000, 1'b1));
        exp_q.push_back(mk_e(4'b0010, 4'b0000, 1'b1, 16'h0101, 16'hD001, 1'b1));
        exp_q.push_back(mk_e(4'b0000, 4'b0000, 1'b0, 16'h0101, 16'hD001, 1'b0));
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin
                #2 rst = 1'b1;
                #1;
            end else begin
                if (k == 5) dm_if.core_req = 4'h0;
                tick();
                if (k == 2) rst = 1'b0;
            end
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) $display("FAIL reset_mid_run step %0d: got %p expected %p", k, o, e);
            else passed++;
        end
    endtask

    task automatic test_run_to_dump();
        exp_t e, o;
        int   k = 0;
        push(mk_s(ST_RUN,  4'b0001, 4'h0, 4'h0, 1'b0, 16'h0040, 16'h7777), mk_e(4'b0001, 4'b0000, 1'b0, 16'h0100, 16'hD000, 1'b1));
        push(mk_s(ST_DUMP, 4'b0001, 4'h0, 4'h0, 1'b1, 16'h0040, 16'h7777), mk_e(4'b0000, 4'b0001, 1'b0, 16'h0040, 16'h7777, 1'b0));
        push(mk_s(ST_DUMP, 4'b0000, 4'h0, 4'h0, 1'b0, 16'h0040, 16'h7777), mk_e(4'b0000, 4'b0000, 1'b0, 16'h0040, 16'h7777, 1'b0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            tick();
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) $display("FAIL run_to_dump step %0d: got %p expected %p", k, o, e);
            else passed++;
            k++;
        end
    endtask

    initial begin
        dm_if.core_addr = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        dm_if.core_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        test_reset();
        test_com_port();
        test_rr_reads();
        test_lone_writer();
        test_lock();
        test_reset_mid_run();
        test_run_to_dump();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
